// File: rtl/pcie_cq_pkg.sv
// pcie_cq_pkg: shared CQ request-type codes, tuser bit positions and receiver states
package pcie_cq_pkg;
    localparam logic [3:0] REQ_MRD = 4'b0000;
    localparam logic [3:0] REQ_MWR = 4'b0001;
    localparam int FIRST_BE    = 0;
    localparam int LAST_BE     = 4;
    localparam int SOP         = 40;
    localparam int DISCONTINUE = 41;
    typedef enum logic [1:0] {ST_IDLE, ST_RD_HOLD, ST_WR_DATA, ST_DROP} state_t;
endpackage

// File: rtl/rx_cq.sv
// rx_cq: CQ completer-request receiver, decodes MRd into a request record and streams MWr payload
module rx_cq
    import pcie_cq_pkg::*;
#(
    parameter int AXI4_CQ_TUSER_WIDTH = 85,
    parameter int C_DATA_WIDTH        = 128,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32
) (
    input  logic                           user_clk,
    input  logic                           user_reset,
    input  logic                           user_lnk_up,
    input  logic [C_DATA_WIDTH-1:0]        m_axis_cq_tdata,
    input  logic [AXI4_CQ_TUSER_WIDTH-1:0] m_axis_cq_tuser,
    input  logic                           m_axis_cq_tlast,
    input  logic [KEEP_WIDTH-1:0]          m_axis_cq_tkeep,
    input  logic                           m_axis_cq_tvalid,
    output logic                           m_axis_cq_tready,
    output logic                           rd_req_valid,
    input  logic                           rd_req_ready,
    output logic [63:0]                    rd_req_addr,
    output logic [10:0]                    rd_req_dw_count,
    output logic [7:0]                     rd_req_tag,
    output logic [15:0]                    rd_req_requester_id,
    output logic [2:0]                     rd_req_tc,
    output logic [2:0]                     rd_req_attr,
    output logic [3:0]                     rd_req_first_be,
    output logic [3:0]                     rd_req_last_be,
    output logic                           wr_valid,
    output logic [63:0]                    wr_addr,
    output logic [C_DATA_WIDTH-1:0]        wr_data,
    output logic [KEEP_WIDTH-1:0]          wr_keep,
    output logic                           wr_last,
    output logic                           wr_abort,
    output logic [15:0]                    unsup_cnt
);
    state_t      state;
    logic [63:0] wptr;
    logic        rst;
    logic        acc;
    logic        sop;
    logic        abort;
    logic [3:0]  req_type;
    logic        unused_bits;
    assign rst         = user_reset | ~user_lnk_up;
    assign acc         = m_axis_cq_tvalid & m_axis_cq_tready;
    assign sop         = m_axis_cq_tuser[SOP];
    assign abort       = m_axis_cq_tuser[DISCONTINUE] | sop;
    assign req_type    = m_axis_cq_tdata[78:75];
    assign unused_bits = ^{m_axis_cq_tuser[AXI4_CQ_TUSER_WIDTH-1:42], m_axis_cq_tuser[39:8],
                           m_axis_cq_tdata[127:124], m_axis_cq_tdata[117:104],
                           m_axis_cq_tdata[79], m_axis_cq_tdata[1:0]};
    always_ff @(posedge user_clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            wptr                <= '0;
            m_axis_cq_tready    <= 1'b0;
            rd_req_valid        <= 1'b0;
            rd_req_addr         <= '0;
            rd_req_dw_count     <= '0;
            rd_req_tag          <= '0;
            rd_req_requester_id <= '0;
            rd_req_tc           <= '0;
            rd_req_attr         <= '0;
            rd_req_first_be     <= '0;
            rd_req_last_be      <= '0;
            wr_valid            <= 1'b0;
            wr_addr             <= '0;
            wr_data             <= '0;
            wr_keep             <= '0;
            wr_last             <= 1'b0;
            wr_abort            <= 1'b0;
            unsup_cnt           <= '0;
        end else begin
            m_axis_cq_tready <= 1'b1;
            wr_valid         <= 1'b0;
            wr_last          <= 1'b0;
            wr_abort         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (acc && sop) begin
                        if (req_type == REQ_MRD && m_axis_cq_tlast) begin
                            rd_req_valid        <= 1'b1;
                            rd_req_addr         <= {m_axis_cq_tdata[63:2], 2'b00};
                            rd_req_dw_count     <= m_axis_cq_tdata[74:64];
                            rd_req_requester_id <= m_axis_cq_tdata[95:80];
                            rd_req_tag          <= m_axis_cq_tdata[103:96];
                            rd_req_tc           <= m_axis_cq_tdata[120:118];
                            rd_req_attr         <= m_axis_cq_tdata[123:121];
                            rd_req_first_be     <= m_axis_cq_tuser[FIRST_BE +: 4];
                            rd_req_last_be      <= m_axis_cq_tuser[LAST_BE +: 4];
                            m_axis_cq_tready    <= 1'b0;
                            state               <= ST_RD_HOLD;
                        end else if (req_type == REQ_MWR && !m_axis_cq_tlast) begin
                            wptr  <= {m_axis_cq_tdata[63:2], 2'b00};
                            state <= ST_WR_DATA;
                        end else begin
                            if (unsup_cnt != 16'hFFFF) unsup_cnt <= unsup_cnt + 16'd1;
                            state <= m_axis_cq_tlast ? ST_IDLE : ST_DROP;
                        end
                    end
                end
                ST_RD_HOLD: begin
                    if (rd_req_ready) begin
                        rd_req_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        m_axis_cq_tready <= 1'b0;
                    end
                end
                ST_WR_DATA: begin
                    if (acc) begin
                        wr_valid <= 1'b1;
                        wr_addr  <= wptr;
                        wr_data  <= m_axis_cq_tdata;
                        wr_keep  <= m_axis_cq_tkeep;
                        wr_last  <= m_axis_cq_tlast | abort;
                        wr_abort <= abort;
                        wptr     <= wptr + 64'd16;
                        state    <= m_axis_cq_tlast ? ST_IDLE : (abort ? ST_DROP : ST_WR_DATA);
                    end
                end
                ST_DROP: if (acc && m_axis_cq_tlast) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_cq.sv
// tb_rx_cq: directed checks of rx_cq read decode, write streaming, drops and link-down reset
module tb_rx_cq;
    logic         user_clk = 1'b0;
    logic         user_reset, user_lnk_up;
    logic [127:0] tdata;
    logic [84:0]  tuser;
    logic         tlast, tvalid, tready;
    logic [3:0]   tkeep;
    logic         rd_req_valid, rd_req_ready;
    logic [63:0]  rd_req_addr;
    logic [10:0]  rd_req_dw_count;
    logic [7:0]   rd_req_tag;
    logic [15:0]  rd_req_requester_id;
    logic [2:0]   rd_req_tc, rd_req_attr;
    logic [3:0]   rd_req_first_be, rd_req_last_be;
    logic         wr_valid, wr_last, wr_abort;
    logic [63:0]  wr_addr;
    logic [127:0] wr_data;
    logic [3:0]   wr_keep;
    logic [15:0]  unsup_cnt;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 user_clk = ~user_clk;

    rx_cq dut (
        .user_clk(user_clk), .user_reset(user_reset), .user_lnk_up(user_lnk_up),
        .m_axis_cq_tdata(tdata), .m_axis_cq_tuser(tuser), .m_axis_cq_tlast(tlast),
        .m_axis_cq_tkeep(tkeep), .m_axis_cq_tvalid(tvalid), .m_axis_cq_tready(tready),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_req_dw_count(rd_req_dw_count), .rd_req_tag(rd_req_tag),
        .rd_req_requester_id(rd_req_requester_id), .rd_req_tc(rd_req_tc),
        .rd_req_attr(rd_req_attr), .rd_req_first_be(rd_req_first_be),
        .rd_req_last_be(rd_req_last_be), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_keep(wr_keep), .wr_last(wr_last), .wr_abort(wr_abort),
        .unsup_cnt(unsup_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] desc(input logic [63:0] addr, input logic [10:0] dwc,
                                          input logic [3:0] rt, input logic [15:0] rid,
                                          input logic [7:0] tg, input logic [2:0] tc,
                                          input logic [2:0] attr);
        logic [127:0] d = '0;
        d[63:0]    = {addr[63:2], 2'b10};
        d[74:64]   = dwc;
        d[78:75]   = rt;
        d[95:80]   = rid;
        d[103:96]  = tg;
        d[120:118] = tc;
        d[123:121] = attr;
        return d;
    endfunction

    function automatic logic [84:0] usr(input logic s, input logic disc, input logic [3:0] fbe,
                                        input logic [3:0] lbe);
        logic [84:0] u = '0;
        u[3:0] = fbe;
        u[7:4] = lbe;
        u[40]  = s;
        u[41]  = disc;
        return u;
    endfunction

    task automatic beat(input logic [127:0] d, input logic [84:0] u, input logic [3:0] k,
                        input logic l);
        tdata  = d;
        tuser  = u;
        tkeep  = k;
        tlast  = l;
        tvalid = 1'b1;
        @(posedge user_clk);
        #1;
        tvalid = 1'b0;
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    initial begin
        user_reset = 1'b1; user_lnk_up = 1'b1; rd_req_ready = 1'b1;
        tdata = '0; tuser = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0;
        repeat (3) tick();
        chk("rst_tready", tready, 0);
        chk("rst_rdv", rd_req_valid, 0);
        chk("rst_wrv", wr_valid, 0);
        chk("rst_unsup", unsup_cnt, 0);
        user_reset = 1'b0;
        tick();
        chk("idle_tready", tready, 1);
        // MRd with ready held high
        beat(desc(64'h0000_1000_0000_0000, 11'd16, 4'b0000, 16'h4508, 8'h05, 3'd2, 3'd1),
             usr(1'b1, 1'b0, 4'hF, 4'hF), 4'hF, 1'b1);
        chk("mrd1_valid", rd_req_valid, 1);
        chk("mrd1_addr", rd_req_addr, 64'h0000_1000_0000_0000);
        chk("mrd1_dwc", rd_req_dw_count, 16);
        chk("mrd1_tag", rd_req_tag, 8'h05);
        chk("mrd1_rid", rd_req_requester_id, 16'h4508);
        chk("mrd1_tc", rd_req_tc, 2);
        chk("mrd1_attr", rd_req_attr, 1);
        chk("mrd1_be", {rd_req_first_be, rd_req_last_be}, 8'hFF);
        chk("mrd1_tready_low", tready, 0);
        tick();
        chk("mrd1_valid_clr", rd_req_valid, 0);
        chk("mrd1_tready_back", tready, 1);
        // MRd stalled for 10 cycles
        rd_req_ready = 1'b0;
        beat(desc(64'h0000_0000_0000_3A00, 11'd2, 4'b0000, 16'h0100, 8'h21, 3'd0, 3'd0),
             usr(1'b1, 1'b0, 4'hF, 4'h3), 4'hF, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("mrd2_valid", rd_req_valid, 1);
            chk("mrd2_addr", rd_req_addr, 64'h3A00);
            chk("mrd2_tag", rd_req_tag, 8'h21);
            chk("mrd2_lbe", rd_req_last_be, 4'h3);
            chk("mrd2_tready", tready, 0);
            tick();
        end
        rd_req_ready = 1'b1;
        tick();
        chk("mrd2_valid_clr", rd_req_valid, 0);
        chk("mrd2_tready_back", tready, 1);
        // MWr 6 DW at 0x2000
        beat(desc(64'h2000, 11'd6, 4'b0001, 16'h0100, 8'h01, 3'd0, 3'd0),
             usr(1'b1, 1'b0, 4'hF, 4'hF), 4'hF, 1'b0);
        chk("mwr_desc_nowr", wr_valid, 0);
        beat(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, usr(1'b0, 1'b0, 4'h0, 4'h0), 4'hF, 1'b0);
        chk("mwr_b0_valid", wr_valid, 1);
        chk("mwr_b0_addr", wr_addr, 64'h2000);
        chk("mwr_b0_keep", wr_keep, 4'hF);
        chk("mwr_b0_data", wr_data, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
        chk("mwr_b0_last", wr_last, 0);
        beat(128'h00000000_00000000_B1B1B1B1_B0B0B0B0, usr(1'b0, 1'b0, 4'h0, 4'h0), 4'h3, 1'b1);
        chk("mwr_b1_valid", wr_valid, 1);
        chk("mwr_b1_addr", wr_addr, 64'h2010);
        chk("mwr_b1_keep", wr_keep, 4'h3);
        chk("mwr_b1_last", wr_last, 1);
        chk("mwr_b1_abort", wr_abort, 0);
        tick();
        chk("mwr_pulse_end", {wr_valid, wr_last}, 0);
        // IO read dropped, then MWr immediately behind it
        beat(desc(64'h80, 11'd1, 4'b0010, 16'h0100, 8'h02, 3'd0, 3'd0),
             usr(1'b1, 1'b0, 4'hF, 4'h0), 4'hF, 1'b1);
        chk("io_unsup", unsup_cnt, 1);
        chk("io_tready", tready, 1);
        chk("io_no_rd", rd_req_valid, 0);
        beat(desc(64'h3000, 11'd4, 4'b0001, 16'h0100, 8'h03, 3'd0, 3'd0),
             usr(1'b1, 1'b0, 4'hF, 4'hF), 4'hF, 1'b0);
        beat(128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, usr(1'b0, 1'b0, 4'h0, 4'h0), 4'hF, 1'b1);
        chk("io_mwr_valid", wr_valid, 1);
        chk("io_mwr_addr", wr_addr, 64'h3000);
        chk("io_mwr_keep", wr_keep, 4'hF);
        chk("io_mwr_last", wr_last, 1);
        // Discontinue on first payload beat of a 3-beat MWr
        beat(desc(64'h4000, 11'd8, 4'b0001, 16'h0100, 8'h04, 3'd0, 3'd0),
             usr(1'b1, 1'b0, 4'hF, 4'hF), 4'hF, 1'b0);
        beat(128'h1, usr(1'b0, 1'b1, 4'h0, 4'h0), 4'hF, 1'b0);
        chk("disc_valid", wr_valid, 1);
        chk("disc_abort", wr_abort, 1);
        chk("disc_last", wr_last, 1);
        chk("disc_addr", wr_addr, 64'h4000);
        beat(128'h2, usr(1'b0, 1'b0, 4'h0, 4'h0), 4'hF, 1'b1);
        chk("disc_dropped", wr_valid, 0);
        chk("disc_unsup", unsup_cnt, 1);
        chk("disc_tready", tready, 1);
        // Link drop during MWr payload
        beat(desc(64'h5000, 11'd8, 4'b0001, 16'h0100, 8'h06, 3'd0, 3'd0),
             usr(1'b1, 1'b0, 4'hF, 4'hF), 4'hF, 1'b0);
        beat(128'h5555, usr(1'b0, 1'b0, 4'h0, 4'h0), 4'hF, 1'b0);
        chk("lnk_pre_wr", wr_valid, 1);
        user_lnk_up = 1'b0;
        tick();
        chk("lnk_tready", tready, 0);
        chk("lnk_wr", {wr_valid, wr_last, wr_abort, wr_keep}, 0);
        chk("lnk_wr_addr", wr_addr, 0);
        chk("lnk_wr_data", wr_data, 0);
        chk("lnk_rd", {rd_req_valid, rd_req_tag}, 0);
        chk("lnk_rd_addr", rd_req_addr, 0);
        chk("lnk_unsup", unsup_cnt, 0);
        user_lnk_up = 1'b1;
        tick();
        chk("lnk_tready_back", tready, 1);
        beat(desc(64'hFEDC_BA98_ABCD_0040, 11'd1, 4'b0000, 16'hBEEF, 8'h77, 3'd7, 3'd5),
             usr(1'b1, 1'b0, 4'hC, 4'h0), 4'hF, 1'b1);
        chk("lnk_mrd_valid", rd_req_valid, 1);
        chk("lnk_mrd_addr", rd_req_addr, 64'hFEDC_BA98_ABCD_0040);
        chk("lnk_mrd_dwc", rd_req_dw_count, 1);
        chk("lnk_mrd_tag", rd_req_tag, 8'h77);
        chk("lnk_mrd_rid", rd_req_requester_id, 16'hBEEF);
        chk("lnk_mrd_tc_attr", {rd_req_tc, rd_req_attr}, 6'b111_101);
        chk("lnk_mrd_be", {rd_req_first_be, rd_req_last_be}, 8'hC0);
        chk("lnk_mrd_nowr", wr_valid, 0);
        tick();
        chk("lnk_mrd_clr", rd_req_valid, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_cq.md
Name: rx_cq

Overview:
- Completer-request receiver for the PCIe IP's AXI4-Stream CQ interface, 128-bit, DWORD-aligned mode.
- Accepts host/SSD-issued requests targeting our BAR, for example the NVMe device reading a submission-queue entry or writing a completion entry.
- Decodes memory reads into a request record for the completion transmitter.
- Streams memory-write payload to a write sink.
- Drops all other request types.

Parameters:
- AXI4_CQ_TUSER_WIDTH, 85, CQ tuser width.
- C_DATA_WIDTH, 128, data width. Only 128 is supported.
- KEEP_WIDTH, C_DATA_WIDTH/32, tkeep width.

Ports:
- user_clk  in  1  clock
- user_reset  in  1  synchronous active-high reset
- user_lnk_up  in  1  link up. Low acts as reset.
- m_axis_cq_tdata  in  128  CQ data
- m_axis_cq_tuser  in  85  [3:0] first_be, [7:4] last_be, [40] sop, [41] discontinue
- m_axis_cq_tlast  in  1  end of TLP
- m_axis_cq_tkeep  in  4  DW valid
- m_axis_cq_tvalid  in  1  beat valid
- m_axis_cq_tready  out  1  beat accept
- rd_req_valid  out  1  read request pending
- rd_req_ready  in  1  completer accepts request
- rd_req_addr  out  64  byte address {desc addr[63:2], 2'b00}
- rd_req_dw_count  out  11  DW count
- rd_req_tag  out  8  tag
- rd_req_requester_id  out  16  requester ID
- rd_req_tc  out  3  traffic class
- rd_req_attr  out  3  attributes
- rd_req_first_be  out  4  first BE
- rd_req_last_be  out  4  last BE
- wr_valid  out  1  payload beat valid (no backpressure)
- wr_addr  out  64  byte address of wr_data DW0
- wr_data  out  128  payload
- wr_keep  out  4  DW valid
- wr_last  out  1  final payload beat
- wr_abort  out  1  write discontinued. Discard the TLP.
- unsup_cnt  out  16  saturating count of dropped TLPs

Behaviour:
- Reset: user_reset=1 or user_lnk_up=0 at a clock edge.
  - All outputs go to 0 and the state goes to ST_IDLE.
  - Any TLP in progress is abandoned.
  - unsup_cnt clears.
- Beat acceptance: a beat is accepted when tvalid && tready.
- Descriptor decode (first beat, tuser[40]=1):
  - DW0/DW1 carry address[63:2]. Bits [1:0] are AT and are ignored.
  - DW2 carries [10:0] dw_count, [14:11] req_type, [31:16] requester_id.
  - DW3 carries [7:0] tag, [24:22] tc, [27:25] attr.
- ST_IDLE:
  - tready=1.
  - On descriptor accept:
    - req_type 4'b0000 (MRd) with tlast=1: latch fields and go to ST_RD_HOLD.
    - req_type 4'b0001 (MWr) with tlast=0: latch the address into the write pointer and go to ST_WR_DATA.
    - Any other type, or a malformed tlast: increment unsup_cnt (saturating at 16'hFFFF). Stay in ST_IDLE if tlast=1, otherwise go to ST_DROP.
- ST_RD_HOLD:
  - tready=0 and rd_req_valid=1. rd_req_valid first rises the cycle after the descriptor is accepted.
  - rd_req_* fields are stable while valid is high.
  - On rd_req_ready=1, deassert valid at the next edge and return to ST_IDLE.
  - tready rises one cycle after the handshake, giving a minimum one-cycle bubble.
- ST_WR_DATA:
  - tready=1.
  - Each accepted beat drives one registered output beat the next cycle:
    - wr_valid=1
    - wr_data = tdata
    - wr_keep = tkeep
    - wr_last = tlast
    - wr_addr = write pointer
  - The write pointer advances by 16 after each beat.
  - tuser[41]=1 on any payload beat sets wr_abort=1 together with that beat and forces wr_last=1. Then go to ST_DROP if tlast=0, else ST_IDLE.
  - tlast=1 returns the state to ST_IDLE.
  - A payload beat carrying sop=1 is a protocol error: treat it as abort.
- ST_DROP:
  - tready=1.
  - Discard beats until tlast is accepted, then go to ST_IDLE.
- Pulse outputs: wr_valid, wr_last and wr_abort are single-cycle pulses. They are 0 whenever no beat was accepted in the previous cycle.
- Back-to-back TLPs: a descriptor beat accepted in ST_IDLE the cycle after a write's tlast is legal.
- The write pointer wraps at 2^64 with no flag.

Decomposition:
- Shared package (pcie_cq_pkg) holds:
  - Request-type constants (REQ_MRD=4'b0000, REQ_MWR=4'b0001).
  - tuser bit-index constants (FIRST_BE, LAST_BE, SOP=40, DISCONTINUE=41).
  - State encodings ST_IDLE, ST_RD_HOLD, ST_WR_DATA, ST_DROP.
- No sub-module. Descriptor field extraction is inline.
- rd_req_* outputs match the fields that the completion transmitter consumes.

Test Plan:
- MRd: addr 64'h0000_1000_0000_0000, dw_count 16, tag 8'h05, req_id 16'h4508, rd_req_ready held 1.
  - rd_req_valid high for exactly one cycle, starting one cycle after accept, with all fields matching.
  - tready low for 1 cycle.
- MRd with rd_req_ready held 0 for 10 cycles.
  - rd_req_valid and fields stable for 10 cycles.
  - tready=0 throughout and no beat accepted.
  - Clears one cycle after ready.
- MWr 6 DW at addr 0x2000.
  - Two wr beats: keep 4'b1111 at addr 0x2000, then keep 4'b0011 at addr 0x2010 with wr_last=1.
  - wr_abort=0.
- IO read (req_type 4'b0010) with tlast=1, followed immediately by an MWr 4 DW.
  - unsup_cnt=1.
  - The MWr yields one beat with keep 4'b1111 and wr_last=1.
- 3-beat MWr (8 DW of payload) with discontinue set on the first payload beat.
  - wr_abort=1 with wr_last=1 on that beat.
  - The remaining beat is dropped and state returns to ST_IDLE.
- user_lnk_up pulsed low during the payload of an MWr.
  - All outputs go to 0 and unsup_cnt=0.
  - The next MRd decodes correctly.
